// File: rtl/pix_sdram_writer.sv
// pix_sdram_writer: buffers a pixel word stream in a FIFO and issues one SDRAM write per word
// at consecutive addresses from BaseAddr, one frame of FrameWords words per capture.
module pix_sdram_writer #(
    parameter int AddrWidth = 25,
    parameter int DataWidth = 16,
    parameter int FifoDepthLog2 = 4,
    parameter logic [AddrWidth-1:0] BaseAddr = '0,
    parameter int FrameWords = 'h1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctrl_en,
    input  logic                 pix_frameStart,
    input  logic                 pix_valid,
    input  logic [DataWidth-1:0] pix_data,
    output logic                 status_busy,
    output logic                 status_frameDone,
    output logic                 status_overflow,
    input  logic                 cmdReady,
    output logic                 cmdTrigger,
    output logic [AddrWidth-1:0] cmdAddr,
    output logic                 cmdWrite,
    output logic [DataWidth-1:0] cmdWriteData
);
    localparam int CW = $clog2(FrameWords) + 1;
    localparam int PW = FifoDepthLog2 + 1;
    localparam logic [PW-1:0] Depth = PW'(2 ** FifoDepthLog2);
    localparam logic [CW-1:0] FrameLen = CW'(FrameWords);
    localparam logic [CW-1:0] FrameLast = CW'(FrameWords - 1);
    if (64'(BaseAddr) + 64'(FrameWords) > (64'(1) << AddrWidth)) begin : g_bad_frame
        $fatal(1, "pix_sdram_writer: frame does not fit in the address space");
    end
    typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, DRAIN} state_t;
    state_t state, state_n;
    logic [DataWidth-1:0] mem [2**FifoDepthLog2];
    logic [FifoDepthLog2-1:0] rd_ptr, wr_ptr, rd_nx;
    logic [PW-1:0] count, rem;
    logic [CW-1:0] push_cnt, accept_cnt, acc_n;
    logic start, push_req, push, pop, last_accept;
    always_comb begin
        start = state == WAIT_FRAME && pix_frameStart;
        push_req = pix_valid && (start || (state == CAPTURE && push_cnt < FrameLen));
        pop = cmdTrigger && cmdReady;
        push = push_req && (count != Depth || pop);
        last_accept = state == DRAIN && pop && accept_cnt == FrameLast;
        acc_n = start ? '0 : accept_cnt + CW'(pop);
        rem = count - PW'(pop);
        rd_nx = rd_ptr + FifoDepthLog2'(pop);
        status_busy = state == CAPTURE || state == DRAIN || count != '0;
        cmdWrite = cmdTrigger;
        state_n = state;
        case (state)
            IDLE: if (ctrl_en) state_n = WAIT_FRAME;
            WAIT_FRAME: if (start) state_n = CAPTURE;
            CAPTURE: if (push && push_cnt == FrameLast) state_n = DRAIN;
            DRAIN: if (last_accept) state_n = WAIT_FRAME;
            default: state_n = IDLE;
        endcase
        if (!ctrl_en) state_n = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= pix_data;
    end
    // The command register mirrors the FIFO head; the head is only popped on an accepted command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            push_cnt <= '0;
            accept_cnt <= '0;
            status_frameDone <= 1'b0;
            status_overflow <= 1'b0;
            cmdTrigger <= 1'b0;
            cmdAddr <= '0;
            cmdWriteData <= '0;
        end else if (!ctrl_en) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            status_frameDone <= 1'b0;
            cmdTrigger <= 1'b0;
        end else begin
            if (state == IDLE) status_overflow <= 1'b0;
            else if (push_req && !push) status_overflow <= 1'b1;
            status_frameDone <= last_accept;
            wr_ptr <= wr_ptr + FifoDepthLog2'(push);
            rd_ptr <= rd_nx;
            count <= count + PW'(push) - PW'(pop);
            push_cnt <= start ? CW'(push) : push_cnt + CW'(push);
            accept_cnt <= acc_n;
            if (!cmdTrigger || cmdReady) begin
                cmdTrigger <= rem != '0 || (pop && push);
                cmdWriteData <= rem != '0 ? mem[rd_nx] : pix_data;
                cmdAddr <= BaseAddr + AddrWidth'(acc_n);
            end
        end
    end
endmodule

// File: tb/tb_pix_sdram_writer.sv
// tb_pix_sdram_writer: directed scenarios checked every cycle against a queue-based model of
// the pixel-to-SDRAM write stream, plus hand-computed expectations per scenario.
module tb_pix_sdram_writer;
    localparam int AW = 12;
    localparam int FW = 20;
    localparam logic [AW-1:0] BASE = 12'h100;
    logic clk = 0, rst = 1, ctrl_en = 0, pix_frameStart = 0, pix_valid = 0, cmdReady = 0;
    logic [15:0] pix_data = '0;
    logic status_busy, status_frameDone, status_overflow, cmdTrigger, cmdWrite;
    logic [AW-1:0] cmdAddr;
    logic [15:0] cmdWriteData;
    always #5 clk = ~clk;
    pix_sdram_writer #(.AddrWidth(AW), .DataWidth(16), .FifoDepthLog2(4), .BaseAddr(BASE),
                       .FrameWords(FW)) dut (
        .clk(clk), .rst(rst), .ctrl_en(ctrl_en), .pix_frameStart(pix_frameStart),
        .pix_valid(pix_valid), .pix_data(pix_data), .status_busy(status_busy),
        .status_frameDone(status_frameDone), .status_overflow(status_overflow),
        .cmdReady(cmdReady), .cmdTrigger(cmdTrigger), .cmdAddr(cmdAddr), .cmdWrite(cmdWrite),
        .cmdWriteData(cmdWriteData));
    int n_tests = 0, n_fail = 0;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    // Model: frame in progress from frameStart until FW words accepted; FIFO of 16 words.
    int m_mode, m_pushed, m_acc, m_occ;
    bit m_take, m_acc_now;
    logic m_ovf, m_done;
    logic [15:0] m_q[$];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_pushed = 0; m_acc = 0; m_ovf = 0; m_done = 0;
            m_q.delete();
        end else begin
            m_acc_now = cmdTrigger && cmdReady;
            m_occ = m_q.size();
            m_take = 0;
            m_done = 0;
            if (!ctrl_en) begin
                m_mode = 0;
                m_q.delete();
            end else begin
                if (m_mode == 0) begin
                    m_mode = 1; m_ovf = 0;
                end else if (m_mode == 1 && pix_frameStart) begin
                    m_mode = 2; m_pushed = 0; m_acc = 0; m_take = pix_valid;
                end else if (m_mode == 2) m_take = pix_valid && m_pushed < FW;
                if (m_acc_now && m_occ > 0) begin
                    void'(m_q.pop_front());
                    m_acc++;
                    if (m_mode == 2 && m_acc == FW) begin
                        m_done = 1; m_mode = 1;
                    end
                end
                if (m_take) begin
                    if (m_occ < 16 || m_acc_now) begin
                        m_q.push_back(pix_data); m_pushed++;
                    end else m_ovf = 1;
                end
            end
        end
    end
    logic [AW-1:0] wa[$];
    logic [15:0] wdq[$];
    int dn = 0;
    bit p_hold = 0;
    logic [AW-1:0] p_addr;
    logic [15:0] p_wd;
    always @(negedge clk) begin
        if (rst) p_hold = 0;
        else begin
            chk("cmdWrite", cmdWrite, cmdTrigger);
            chk("overflow", status_overflow, m_ovf);
            chk("frameDone", status_frameDone, m_done);
            chk("busy", status_busy, (m_mode == 2) || (m_q.size() != 0));
            if (cmdTrigger) begin
                chk("trig_has_word", m_q.size() != 0, 1);
                if (m_q.size() != 0) begin
                    chk("cmd_addr", cmdAddr, 32'(BASE) + m_acc);
                    chk("cmd_data", cmdWriteData, m_q[0]);
                end
            end
            if (p_hold) begin
                chk("hold_trig", cmdTrigger, 1);
                chk("hold_addr", cmdAddr, p_addr);
                chk("hold_data", cmdWriteData, p_wd);
            end
            if (cmdTrigger && cmdReady) begin
                wa.push_back(cmdAddr); wdq.push_back(cmdWriteData);
            end
            if (status_frameDone) dn++;
            p_hold = cmdTrigger && !cmdReady && ctrl_en;
            p_addr = cmdAddr;
            p_wd = cmdWriteData;
        end
    end
    task automatic px(input logic f, input logic v, input logic [15:0] d);
        pix_frameStart = f; pix_valid = v; pix_data = d;
        @(posedge clk); #2;
        pix_frameStart = 0; pix_valid = 0;
    endtask
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask
    task automatic frame(input logic [15:0] b);
        px(1, 1, b);
        for (int i = 1; i < FW; i++) px(0, 1, b + 16'(i));
    endtask
    task automatic wait_idle();
        int k = 0;
        while ((status_busy || cmdTrigger) && k < 300) begin @(negedge clk); k++; end
        chk("drain_timeout", k < 300, 1);
        idle(2);
    endtask
    task automatic clr();
        wa.delete(); wdq.delete(); dn = 0;
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        @(posedge clk); #2;
        chk("rst_trig", cmdTrigger, 0);
        chk("rst_addr", cmdAddr, 0);
        chk("rst_data", cmdWriteData, 0);
        chk("rst_busy", status_busy, 0);
        rst = 0; ctrl_en = 1; cmdReady = 1;
        idle(2);
        // 1: one frame at full speed, including first-word latency
        clr();
        px(1, 1, 16'h0);
        @(negedge clk) chk("t1_lat_trig0", cmdTrigger, 0);
        px(0, 1, 16'h1);
        @(negedge clk);
        chk("t1_lat_trig1", cmdTrigger, 1);
        chk("t1_first_addr", cmdAddr, 12'h100);
        chk("t1_first_data", cmdWriteData, 16'h0);
        for (int i = 2; i < FW; i++) px(0, 1, 16'(i));
        wait_idle();
        chk("t1_writes", wa.size(), 20);
        chk("t1_last_addr", wa[19], 12'h113);
        chk("t1_last_data", wdq[19], 16'd19);
        chk("t1_done_cnt", dn, 1);
        // 2: stalled controller overflows after the 17th word
        clr(); cmdReady = 0;
        px(1, 1, 16'hA0);
        for (int i = 1; i < 20; i++) begin
            px(0, 1, 16'hA0 + 16'(i));
            if (i == 15) chk("t2_ovf_16th", status_overflow, 0);
            if (i == 16) chk("t2_ovf_17th", status_overflow, 1);
        end
        cmdReady = 1;
        idle(40);
        chk("t2_writes", wa.size(), 16);
        chk("t2_addr15", wa[15], 12'h10F);
        chk("t2_data15", wdq[15], 16'hAF);
        chk("t2_busy_mid", status_busy, 1);
        for (int i = 0; i < 4; i++) px(0, 1, 16'hB0 + 16'(i));
        wait_idle();
        chk("t2_writes_all", wa.size(), 20);
        chk("t2_data16", wdq[16], 16'hB0);
        chk("t2_done_cnt", dn, 1);
        // 3: controller ready toggling every cycle
        clr();
        fork
            frame(16'h300);
            repeat (50) begin @(posedge clk); #2; cmdReady = ~cmdReady; end
        join
        cmdReady = 1;
        wait_idle();
        begin
            int bad = 0;
            foreach (wa[i]) if (wa[i] !== BASE + 12'(i) || wdq[i] !== 16'h300 + 16'(i)) bad++;
            chk("t3_seq_errors", bad, 0);
        end
        chk("t3_writes", wa.size(), 20);
        // 4: extra words and a second frameStart inside the frame are ignored
        clr();
        px(1, 1, 16'h400);
        for (int i = 1; i < 26; i++) px(i == 10, 1, 16'h400 + 16'(i));
        wait_idle();
        chk("t4_writes", wa.size(), 20);
        chk("t4_last_data", wdq[19], 16'h413);
        chk("t4_done_cnt", dn, 1);
        // 5: asynchronous reset while draining
        clr();
        px(1, 1, 16'h500);
        for (int i = 1; i < FW; i++) begin
            if (i == 10) cmdReady = 0;
            px(0, 1, 16'h500 + 16'(i));
        end
        chk("t5_pre_trig", cmdTrigger, 1);
        @(posedge clk); #3 rst = 1;
        #1;
        chk("t5_rst_trig", cmdTrigger, 0);
        chk("t5_rst_addr", cmdAddr, 0);
        chk("t5_rst_data", cmdWriteData, 0);
        chk("t5_rst_busy", status_busy, 0);
        chk("t5_rst_ovf", status_overflow, 0);
        @(posedge clk); #2 rst = 0;
        cmdReady = 1;
        idle(2);
        clr();
        frame(16'h550);
        wait_idle();
        chk("t5_writes", wa.size(), 20);
        chk("t5_first_addr", wa[0], 12'h100);
        // 6: disable mid-capture with words buffered
        clr(); cmdReady = 0;
        px(1, 1, 16'h600);
        for (int i = 1; i < 5; i++) px(0, 1, 16'h600 + 16'(i));
        idle(1);
        chk("t6_pre_trig", cmdTrigger, 1);
        ctrl_en = 0;
        idle(1);
        chk("t6_trig_off", cmdTrigger, 0);
        chk("t6_busy_off", status_busy, 0);
        cmdReady = 1;
        for (int i = 0; i < 4; i++) px(i == 0, 1, 16'h6F0 + 16'(i));
        idle(5);
        chk("t6_no_writes", wa.size(), 0);
        ctrl_en = 1;
        idle(2);
        frame(16'h700);
        wait_idle();
        chk("t6_writes", wa.size(), 20);
        chk("t6_first_addr", wa[0], 12'h100);
        chk("t6_first_data", wdq[0], 16'h700);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
